hazard_stall_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/hazard_stall_ctrl_if.sv | 38 +++
 rtl/hazard_stall_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for hazard_stall_ctrl: stage register fields, memory handshake
// and the control/forwarding outputs. master = pipeline datapath, slave = controller.
interface hazard_stall_ctrl_if #(
  parameter int PERF_W = 16
);
  logic [3:0]        ID_Rn, ID_Rm, ID_Rd;
  logic              ID_use_n, ID_use_m, ID_use_d;
  logic [3:0]        EX_Rd;
  logic              EX_RF_enable, EX_Load_Inst;
  logic [3:0]        MEM_Rd;
  logic              MEM_RF_enable, MEM_m_enable;
  logic [3:0]        WB_Rd;
  logic              WB_RF_enable;
  logic              branch_taken;
  logic              mem_ready;
  logic              PC_Ld, IF_ID_Ld, IF_ID_flush, nop_sel, pipe_hold;
  logic [1:0]        fwd_a, fwd_b, fwd_c;
  logic              mem_timeout;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output ID_Rn, ID_Rm, ID_Rd, ID_use_n, ID_use_m, ID_use_d,
           EX_Rd, EX_RF_enable, EX_Load_Inst,
           MEM_Rd, MEM_RF_enable, MEM_m_enable,
           WB_Rd, WB_RF_enable, branch_taken, mem_ready,
    input  PC_Ld, IF_ID_Ld, IF_ID_flush, nop_sel, pipe_hold,
           fwd_a, fwd_b, fwd_c, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_Rn, ID_Rm, ID_Rd, ID_use_n, ID_use_m, ID_use_d,
           EX_Rd, EX_RF_enable, EX_Load_Inst,
           MEM_Rd, MEM_RF_enable, MEM_m_enable,
           WB_Rd, WB_RF_enable, branch_taken, mem_ready,
    output PC_Ld, IF_ID_Ld, IF_ID_flush, nop_sel, pipe_hold,
           fwd_a, fwd_b, fwd_c, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, branch flushes,
// data-memory wait hold and operand forwarding. Optional perf counters: HAZARD_PERF_EN.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 8,
  parameter int          PERF_W       = 16
) (
  input logic            CLK,
  input logic            CLR,
  hazard_stall_ctrl_if.slave hz
);

  localparam int unsigned WCW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_WAIT_MAX);

  typedef enum logic {RUN, MWAIT} state_t;

  state_t         state, state_nx;
  logic [WCW-1:0] wait_cnt, wait_cnt_nx;
  logic           timeout_q;
  logic           mem_wait, load_use;
  logic           pc_ld, ifid_ld, ifid_flush, nop, hold;

  function automatic logic [1:0] fwd_sel(
    input logic use_r, input logic [3:0] r,
    input logic [3:0] ex_rd, input logic ex_en, input logic ex_ld,
    input logic [3:0] mem_rd, input logic mem_en,
    input logic [3:0] wb_rd, input logic wb_en
  );
    if (!use_r || r == 4'd15)            return 2'b00;
    else if (ex_en && !ex_ld && ex_rd == r) return 2'b01;
    else if (mem_en && mem_rd == r)      return 2'b10;
    else if (wb_en && wb_rd == r)        return 2'b11;
    else                                 return 2'b00;
  endfunction

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      timeout_q <= timeout_q | (wait_cnt_nx == WAIT_MAX);
    end
  end

  // The entry cycle already holds the pipe, so it counts as a wait cycle too.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = '0;
    mem_wait    = 1'b0;
    pc_ld       = 1'b1;
    ifid_ld     = 1'b1;
    ifid_flush  = 1'b0;
    nop         = 1'b0;
    hold        = 1'b0;
    load_use    = hz.EX_Load_Inst && hz.EX_RF_enable &&
                  ((hz.ID_use_n && hz.ID_Rn == hz.EX_Rd) ||
                   (hz.ID_use_m && hz.ID_Rm == hz.EX_Rd) ||
                   (hz.ID_use_d && hz.ID_Rd == hz.EX_Rd));

    case (state)
      RUN:     mem_wait = hz.MEM_m_enable && !hz.mem_ready;
      MWAIT:   mem_wait = !hz.mem_ready;
      default: mem_wait = 1'b0;
    endcase

    state_nx = mem_wait ? MWAIT : RUN;
    if (mem_wait)
      wait_cnt_nx = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

    if (mem_wait) begin
      pc_ld   = 1'b0;
      ifid_ld = 1'b0;
      hold    = 1'b1;
    end else if (hz.branch_taken) begin
      ifid_flush = 1'b1;
      nop        = 1'b1;
    end else if (load_use) begin
      pc_ld   = 1'b0;
      ifid_ld = 1'b0;
      nop     = 1'b1;
    end
  end

  assign hz.PC_Ld       = pc_ld;
  assign hz.IF_ID_Ld    = ifid_ld;
  assign hz.IF_ID_flush = ifid_flush;
  assign hz.nop_sel     = nop;
  assign hz.pipe_hold   = hold;
  assign hz.mem_timeout = timeout_q;

  assign hz.fwd_a = fwd_sel(hz.ID_use_n, hz.ID_Rn, hz.EX_Rd, hz.EX_RF_enable, hz.EX_Load_Inst,
                            hz.MEM_Rd, hz.MEM_RF_enable, hz.WB_Rd, hz.WB_RF_enable);
  assign hz.fwd_b = fwd_sel(hz.ID_use_m, hz.ID_Rm, hz.EX_Rd, hz.EX_RF_enable, hz.EX_Load_Inst,
                            hz.MEM_Rd, hz.MEM_RF_enable, hz.WB_Rd, hz.WB_RF_enable);
  assign hz.fwd_c = fwd_sel(hz.ID_use_d, hz.ID_Rd, hz.EX_Rd, hz.EX_RF_enable, hz.EX_Load_Inst,
                            hz.MEM_Rd, hz.MEM_RF_enable, hz.WB_Rd, hz.WB_RF_enable);

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_q, flush_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_ld)     stall_q <= stall_q + 1'b1;
      if (ifid_flush) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`else
  assign hz.stall_cnt = PERF_W'(0);
  assign hz.flush_cnt = PERF_W'(0);
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl (MEM_WAIT_MAX=8, PERF_W=16).
module tb_hazard_stall_ctrl;

  localparam int unsigned WMAX = 8;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.PERF_W(16)) bus ();

  hazard_stall_ctrl #(.MEM_WAIT_MAX(WMAX), .PERF_W(16)) dut (
    .CLK (clk),
    .CLR (clr),
    .hz  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.ID_Rn = 4'd0; bus.ID_Rm = 4'd0; bus.ID_Rd = 4'd0;
    bus.ID_use_n = 1'b0; bus.ID_use_m = 1'b0; bus.ID_use_d = 1'b0;
    bus.EX_Rd = 4'd0; bus.EX_RF_enable = 1'b0; bus.EX_Load_Inst = 1'b0;
    bus.MEM_Rd = 4'd0; bus.MEM_RF_enable = 1'b0; bus.MEM_m_enable = 1'b0;
    bus.WB_Rd = 4'd0; bus.WB_RF_enable = 1'b0;
    bus.branch_taken = 1'b0; bus.mem_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_perf(input string tag, input int st, input int fl);
    chk({tag, "_stall_cnt"}, 32'(bus.stall_cnt), PERF ? st : 0);
    chk({tag, "_flush_cnt"}, 32'(bus.flush_cnt), PERF ? fl : 0);
  endtask

  initial begin
    clr = 1'b0;
    idle();
    #12;
    chk("rst_pc_ld", 32'(bus.PC_Ld), 1);
    chk("rst_ifid_ld", 32'(bus.IF_ID_Ld), 1);
    chk("rst_hold", 32'(bus.pipe_hold), 0);
    chk("rst_nop", 32'(bus.nop_sel), 0);
    chk("rst_timeout", 32'(bus.mem_timeout), 0);
    chk_perf("rst", 0, 0);
    clr = 1'b1;
    step();

    // load-use: LDR R3 in EX, ADD reads R3
    bus.EX_Rd = 4'd3; bus.EX_RF_enable = 1'b1; bus.EX_Load_Inst = 1'b1;
    bus.ID_Rn = 4'd3; bus.ID_use_n = 1'b1;
    #1;
    chk("lu_pc_ld", 32'(bus.PC_Ld), 0);
    chk("lu_ifid_ld", 32'(bus.IF_ID_Ld), 0);
    chk("lu_nop", 32'(bus.nop_sel), 1);
    chk("lu_flush", 32'(bus.IF_ID_flush), 0);
    chk("lu_fwd_a", 32'(bus.fwd_a), 0);
    step();
    // load moves to MEM, bubble in EX
    bus.EX_RF_enable = 1'b0; bus.EX_Load_Inst = 1'b0;
    bus.MEM_Rd = 4'd3; bus.MEM_RF_enable = 1'b1;
    #1;
    chk("lu2_fwd_a", 32'(bus.fwd_a), 2);
    chk("lu2_pc_ld", 32'(bus.PC_Ld), 1);
    chk("lu2_nop", 32'(bus.nop_sel), 0);
    step();

    // forwarding priority on Rm=2
    idle();
    bus.EX_Rd = 4'd2; bus.EX_RF_enable = 1'b1;
    bus.MEM_Rd = 4'd2; bus.MEM_RF_enable = 1'b1;
    bus.WB_Rd = 4'd2; bus.WB_RF_enable = 1'b1;
    bus.ID_Rm = 4'd2; bus.ID_use_m = 1'b1;
    #1;
    chk("fwd_b_ex", 32'(bus.fwd_b), 1);
    chk("fwd_b_ex_pc", 32'(bus.PC_Ld), 1);
    step();
    bus.EX_RF_enable = 1'b0;
    #1;
    chk("fwd_b_mem", 32'(bus.fwd_b), 2);
    step();
    bus.MEM_RF_enable = 1'b0;
    #1;
    chk("fwd_b_wb", 32'(bus.fwd_b), 3);
    step();
    bus.EX_RF_enable = 1'b1; bus.MEM_RF_enable = 1'b1;
    bus.EX_Rd = 4'd15; bus.MEM_Rd = 4'd15; bus.WB_Rd = 4'd15; bus.ID_Rm = 4'd15;
    #1;
    chk("fwd_b_r15", 32'(bus.fwd_b), 0);
    step();
    bus.EX_Rd = 4'd2; bus.MEM_Rd = 4'd2; bus.WB_Rd = 4'd2; bus.ID_Rm = 4'd2;
    bus.ID_use_m = 1'b0;
    #1;
    chk("fwd_b_unused", 32'(bus.fwd_b), 0);
    step();

    // store data Rd=2: load in EX (not forwardable) -> MEM wins, and a load-use stall
    idle();
    bus.EX_Rd = 4'd2; bus.EX_RF_enable = 1'b1; bus.EX_Load_Inst = 1'b1;
    bus.MEM_Rd = 4'd2; bus.MEM_RF_enable = 1'b1;
    bus.ID_Rd = 4'd2; bus.ID_use_d = 1'b1;
    #1;
    chk("st_fwd_c", 32'(bus.fwd_c), 2);
    chk("st_pc_ld", 32'(bus.PC_Ld), 0);
    step();

    // branch together with the same load-use: branch wins
    bus.branch_taken = 1'b1;
    #1;
    chk("br_flush", 32'(bus.IF_ID_flush), 1);
    chk("br_nop", 32'(bus.nop_sel), 1);
    chk("br_pc_ld", 32'(bus.PC_Ld), 1);
    step();
    idle();
    #1;
    chk("br_after_flush", 32'(bus.IF_ID_flush), 0);
    chk_perf("br", 2, 1);

    // 3-cycle memory wait, forwarding still valid while held
    bus.MEM_m_enable = 1'b1; bus.mem_ready = 1'b0;
    bus.MEM_Rd = 4'd5; bus.MEM_RF_enable = 1'b1;
    bus.ID_Rn = 4'd5; bus.ID_use_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      chk("mw_hold", 32'(bus.pipe_hold), 1);
      chk("mw_pc_ld", 32'(bus.PC_Ld), 0);
      chk("mw_ifid_ld", 32'(bus.IF_ID_Ld), 0);
      chk("mw_nop", 32'(bus.nop_sel), 0);
      chk("mw_fwd_a", 32'(bus.fwd_a), 2);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("mw_done_hold", 32'(bus.pipe_hold), 0);
    chk("mw_done_pc_ld", 32'(bus.PC_Ld), 1);
    step();
    idle();
    #1;
    chk("mw_run_hold", 32'(bus.pipe_hold), 0);
    chk("mw_timeout", 32'(bus.mem_timeout), 0);
    chk_perf("mw", 5, 1);

    // timeout after MEM_WAIT_MAX waiting cycles, sticky
    bus.MEM_m_enable = 1'b1; bus.mem_ready = 1'b0;
    for (int unsigned i = 0; i < WMAX - 1; i++) step();
    #1;
    chk("to_not_yet", 32'(bus.mem_timeout), 0);
    chk("to_hold", 32'(bus.pipe_hold), 1);
    step();
    chk("to_set", 32'(bus.mem_timeout), 1);
    bus.mem_ready = 1'b1;
    #1;
    chk("to_release_hold", 32'(bus.pipe_hold), 0);
    step();
    idle();
    #1;
    chk("to_sticky", 32'(bus.mem_timeout), 1);
    chk_perf("to", 5 + WMAX, 1);
    step();

    // asynchronous reset in the middle of a wait
    bus.MEM_m_enable = 1'b1; bus.mem_ready = 1'b0;
    step();
    step();
    bus.MEM_m_enable = 1'b0;
    #1;
    chk("ar_in_mwait", 32'(bus.pipe_hold), 1);
    clr = 1'b0;
    #1;
    chk("ar_hold", 32'(bus.pipe_hold), 0);
    chk("ar_pc_ld", 32'(bus.PC_Ld), 1);
    chk("ar_timeout", 32'(bus.mem_timeout), 0);
    chk_perf("ar", 0, 0);
    #2;
    clr = 1'b1;
    idle();
    step();
    chk("ar_run_pc_ld", 32'(bus.PC_Ld), 1);
    chk("ar_run_fwd_a", 32'(bus.fwd_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
